// File: rtl/arb_rr_4.sv
// Four-way round-robin arbiter with registered grant outputs and a dead cycle between grants.
// Defining ARB_TIMEOUT_EN adds an 8-bit hold counter that forces release after HOLD_MAX cycles.
module arb_rr_4 #(
   parameter logic [7:0] HOLD_MAX = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0] state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx_q, idx_d;
   logic       vld_q, vld_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel;
   logic [1:0] cand;
   logic       found;
   logic       dropRel;
   logic       forcedRel;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;

   assign forcedRel = (hold_q == (HOLD_MAX - 8'd1));
   assign timeout   = timeout_q;
`else
   logic unusedHoldMax;

   assign unusedHoldMax = ^HOLD_MAX;
   assign forcedRel     = 1'b0;
   assign timeout       = 1'b0;
`endif

   // Rotating priority: first set request at or above ptr, wrapping modulo 4.
   always_comb begin
      sel   = ptr_q;
      cand  = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   assign dropRel = !req[idx_q] || !en;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (en && (req != 4'b0000)) begin
               state_d = GRANT;
               idx_d   = sel;
               vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_d  = 8'd0;
`endif
            end
         end
         GRANT: begin
            if (dropRel || forcedRel) begin
               state_d = IDLE;
               vld_d   = 1'b0;
               ptr_d   = idx_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
               // A voluntary drop on the limit cycle is not reported as a timeout.
               timeout_d = forcedRel && !dropRel;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            vld_d   = 1'b0;
         end
      endcase
      gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         idx_q   <= 2'd0;
         vld_q   <= 1'b0;
         gnt_q   <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;

endmodule
